// File: rtl/bus_trace_capture.sv
// Bus-cycle trace engine for a 68k-style multiplexed bus: captures completed cycles into a
// circular buffer under a selectable trigger, then streams the buffer as framed bytes.
module bus_trace_capture #(
    parameter int unsigned AD_WIDTH  = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned POST_TRIG = DEPTH / 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_as_n,
    input  logic                      bus_ds_n,
    input  logic                      bus_rw,
    input  logic [AD_WIDTH-1:0]       bus_ad,
    input  logic [1:0]                bus_dsack_n,
    input  logic                      bus_berr_n,
    input  logic                      arm,
    input  logic [1:0]                trig_mode,
    input  logic [AD_WIDTH-1:0]       trig_addr,
    input  logic [AD_WIDTH-1:0]       trig_mask,
    input  logic                      dump_start,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [2:0]                state_o,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned REC_W   = 8 + TS_WIDTH + 2 * AD_WIDTH;
    localparam int unsigned FRAME_W = REC_W + 8;
    localparam int unsigned FRAME_B = FRAME_W / 8;
    localparam int unsigned BIW     = $clog2(FRAME_B);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_DUMP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [1:0]          as_sy, ds_sy, rw_sy, berr_sy;
    logic [1:0]          dsack_sy1, dsack_sy2;
    logic [AD_WIDTH-1:0] ad_sy1, ad_sy2;
    logic                as_prev;
    logic                as_fall, as_rise;

    logic [TS_WIDTH-1:0] ts_cnt, cur_ts;
    logic [AD_WIDTH-1:0] cur_addr, cur_data;
    logic [1:0]          cur_dsack;
    logic                cur_rw, cur_berr, in_cycle, acked;

    logic [AW-1:0]       wr_ptr, wr_ptr_nxt, rd_ptr;
    logic [CW-1:0]       count_nxt, post_cnt, left;
    logic                capturing, commit, trig_hit, arm_go, dump_go, trig_go;
    logic [REC_W-1:0]    mem [DEPTH];
    logic [REC_W-1:0]    rec_in, rec_q;
    logic                loaded;
    logic [BIW-1:0]      byte_idx;
    logic [FRAME_W-1:0]  frame_sh;

    // Two-flop synchronisers on every bus input; edges are taken from the synced strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            as_sy     <= 2'b11;
            ds_sy     <= 2'b11;
            rw_sy     <= 2'b00;
            berr_sy   <= 2'b11;
            dsack_sy1 <= 2'b11;
            dsack_sy2 <= 2'b11;
            ad_sy1    <= '0;
            ad_sy2    <= '0;
            as_prev   <= 1'b1;
        end else begin
            as_sy     <= {as_sy[0], bus_as_n};
            ds_sy     <= {ds_sy[0], bus_ds_n};
            rw_sy     <= {rw_sy[0], bus_rw};
            berr_sy   <= {berr_sy[0], bus_berr_n};
            dsack_sy1 <= bus_dsack_n;
            dsack_sy2 <= dsack_sy1;
            ad_sy1    <= bus_ad;
            ad_sy2    <= ad_sy1;
            as_prev   <= as_sy[1];
        end
    end

    assign as_fall    = as_prev & ~as_sy[1];
    assign as_rise    = ~as_prev & as_sy[1];
    assign capturing  = (state_q == S_ARMED) || (state_q == S_POST);
    assign commit     = as_rise && in_cycle && capturing;
    assign count_nxt  = (commit && count != CW'(DEPTH)) ? count + CW'(1) : count;
    assign wr_ptr_nxt = commit ? wr_ptr + AW'(1) : wr_ptr;
    assign rec_in     = {4'b0000, cur_rw, cur_berr, cur_dsack, cur_ts, cur_addr, cur_data};
    assign state_o    = state_q;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = ((cur_addr ^ trig_addr) & trig_mask) == '0;
            2'd2:    trig_hit = cur_berr;
            default: trig_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state; dump_start takes priority over arm and over any same-clock trigger.
    always_comb begin
        state_d = state_q;
        arm_go  = 1'b0;
        dump_go = 1'b0;
        trig_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    arm_go  = 1'b1;
                end
            end
            S_ARMED: begin
                if (dump_start) begin
                    state_d = S_DUMP;
                    dump_go = 1'b1;
                end else if (commit) begin
                    if (trig_mode == 2'd3) begin
                        if (count >= CW'(DEPTH - 1)) state_d = S_DONE;
                    end else if (trig_hit) begin
                        trig_go = 1'b1;
                        state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (dump_start) begin
                    state_d = S_DUMP;
                    dump_go = 1'b1;
                end else if (commit && post_cnt == CW'(POST_TRIG - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (dump_start) begin
                    state_d = S_DUMP;
                    dump_go = 1'b1;
                end else if (arm) begin
                    state_d = S_ARMED;
                    arm_go  = 1'b1;
                end
            end
            S_DUMP: begin
                if (tx_valid && tx_ready && left == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Cycle capture, timestamp and write-side bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt    <= '0;
            cur_ts    <= '0;
            cur_addr  <= '0;
            cur_data  <= '0;
            cur_dsack <= '0;
            cur_rw    <= 1'b0;
            cur_berr  <= 1'b0;
            in_cycle  <= 1'b0;
            acked     <= 1'b0;
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
        end else begin
            ts_cnt <= (&ts_cnt) ? ts_cnt : ts_cnt + TS_WIDTH'(1);
            if (arm_go) begin
                wr_ptr <= '0;
                count  <= '0;
                ts_cnt <= '0;
            end else if (commit) begin
                wr_ptr   <= wr_ptr_nxt;
                count    <= count_nxt;
                ts_cnt   <= '0;
                in_cycle <= 1'b0;
            end
            if (trig_go)                          post_cnt <= '0;
            else if (commit && state_q == S_POST) post_cnt <= post_cnt + CW'(1);

            if (!capturing) begin
                in_cycle <= 1'b0;
            end else if (as_fall) begin
                in_cycle  <= 1'b1;
                acked     <= 1'b0;
                cur_addr  <= ad_sy2;
                cur_rw    <= rw_sy[1];
                cur_ts    <= ts_cnt;
                cur_data  <= '0;
                cur_dsack <= '0;
                cur_berr  <= 1'b0;
            end else if (in_cycle && !acked && !ds_sy[1] &&
                         (dsack_sy2 != 2'b11 || !berr_sy[1])) begin
                acked     <= 1'b1;
                cur_data  <= ad_sy2;
                cur_dsack <= ~dsack_sy2;
                cur_berr  <= ~berr_sy[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr] <= rec_in;
    end

    assign frame_sh = {8'hA5, rec_q} << {byte_idx, 3'b000};

    // Dump engine: load a record, emit its bytes MSB-first, one idle clock after each accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            rd_ptr   <= '0;
            left     <= '0;
            byte_idx <= '0;
            loaded   <= 1'b0;
            rec_q    <= '0;
        end else if (dump_go) begin
            rd_ptr   <= (count_nxt == CW'(DEPTH)) ? wr_ptr_nxt : '0;
            left     <= count_nxt;
            byte_idx <= '0;
            loaded   <= 1'b0;
            tx_valid <= 1'b0;
        end else if (state_q == S_DUMP) begin
            if (tx_valid) begin
                if (tx_ready) begin
                    tx_valid <= 1'b0;
                    if (left != '0) begin
                        if (byte_idx == BIW'(FRAME_B - 1)) begin
                            byte_idx <= '0;
                            loaded   <= 1'b0;
                            rd_ptr   <= rd_ptr + AW'(1);
                            left     <= left - CW'(1);
                        end else begin
                            byte_idx <= byte_idx + BIW'(1);
                        end
                    end
                end
            end else if (left == '0) begin
                tx_valid <= 1'b1;
                tx_data  <= 8'h5A;
            end else if (!loaded) begin
                rec_q  <= mem[rd_ptr];
                loaded <= 1'b1;
            end else begin
                tx_valid <= 1'b1;
                tx_data  <= frame_sh[FRAME_W-1 -: 8];
            end
        end else begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_trace_capture.sv
// Scoreboard bench for bus_trace_capture (DEPTH=4, POST_TRIG=2): directed bus cycles feed a
// reference buffer; the monitor checks every dumped byte against the expected queue.
module tb_bus_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_as_n = 1'b1, bus_ds_n = 1'b1, bus_rw = 1'b0, bus_berr_n = 1'b1;
    logic [31:0] bus_ad = '0;
    logic [1:0]  bus_dsack_n = 2'b11;
    logic        arm = 1'b0, dump_start = 1'b0, tx_ready = 1'b0;
    logic [1:0]  trig_mode = 2'd0;
    logic [31:0] trig_addr = '0, trig_mask = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [2:0]  state_o;
    logic [2:0]  count;

    bus_trace_capture #(.AD_WIDTH(32), .DEPTH(4), .TS_WIDTH(16), .POST_TRIG(2)) dut (
        .clk(clk), .reset(reset), .bus_as_n(bus_as_n), .bus_ds_n(bus_ds_n), .bus_rw(bus_rw),
        .bus_ad(bus_ad), .bus_dsack_n(bus_dsack_n), .bus_berr_n(bus_berr_n), .arm(arm),
        .trig_mode(trig_mode), .trig_addr(trig_addr), .trig_mask(trig_mask),
        .dump_start(dump_start), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .state_o(state_o), .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0, acc_cnt = 0;
    logic [7:0] exp_q[$];

    // Reference trace buffer
    logic [31:0] m_addr[4], m_data[4];
    logic [15:0] m_ts[4];
    logic [7:0]  m_flags[4];
    int m_wr = 0, m_cnt = 0, last_clear = 0;
    bit cap_on = 0;

    logic       prev_stall = 1'b0, prev_acc = 1'b0;
    logic [7:0] prev_data = '0;

    // Monitor: pops one expected byte per accepted transfer, checks hold-while-stalled and gap.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_stall) begin
                n_chk++;
                if (!tx_valid || tx_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%0b data=%02h required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (prev_acc) begin
                n_chk++;
                if (tx_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL byte_gap: valid=%0b required 0 after accept", tx_valid);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_acc   = tx_valid && tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %02h required none (unexpected byte)", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic do_arm();
        int edge_no;
        arm = 1'b1;
        edge_no = cyc + 1;
        tick(1);
        arm = 1'b0;
        last_clear = edge_no;
        m_wr = 0;
        m_cnt = 0;
    endtask

    // One bus cycle; address/strobe detection lands 3 clocks after the drive point.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic rw,
                             input logic [1:0] dsack_n, input logic berr_n, input bit ack);
        int tsv, fe;
        logic [7:0] fl;
        fe = cyc + 3;
        tsv = fe - last_clear - 1;
        if (tsv > 65535) tsv = 65535;
        bus_as_n = 1'b0;
        bus_rw   = rw;
        bus_ad   = a;
        tick(2);
        if (ack) begin
            bus_ds_n    = 1'b0;
            bus_ad      = d;
            bus_dsack_n = dsack_n;
            bus_berr_n  = berr_n;
        end
        tick(2);
        bus_as_n = 1'b1;
        bus_ds_n = 1'b1;
        bus_dsack_n = 2'b11;
        bus_berr_n = 1'b1;
        bus_ad = '0;
        if (cap_on) begin
            fl = ack ? {4'b0000, rw, ~berr_n, ~dsack_n} : {4'b0000, rw, 3'b000};
            m_addr[m_wr]  = a;
            m_data[m_wr]  = ack ? d : 32'h0;
            m_ts[m_wr]    = 16'(tsv);
            m_flags[m_wr] = fl;
            m_wr = (m_wr + 1) % 4;
            if (m_cnt < 4) m_cnt++;
            last_clear = cyc + 3;
        end
        tick(3);
        tick(1);
    endtask

    task automatic push_expected();
        int start, k;
        start = (m_cnt == 4) ? m_wr : 0;
        for (int i = 0; i < m_cnt; i++) begin
            k = (start + i) % 4;
            exp_q.push_back(8'hA5);
            exp_q.push_back(m_flags[k]);
            exp_q.push_back(m_ts[k][15:8]);
            exp_q.push_back(m_ts[k][7:0]);
            for (int b = 3; b >= 0; b--) exp_q.push_back(m_addr[k][b*8 +: 8]);
            for (int b = 3; b >= 0; b--) exp_q.push_back(m_data[k][b*8 +: 8]);
        end
        exp_q.push_back(8'h5A);
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick(1);
        dump_start = 1'b0;
    endtask

    // mode 0: sink always ready; mode 1: stalled 10 clocks, then toggling.
    task automatic run_dump(input int mode);
        int k;
        bit done;
        k = 0;
        done = 0;
        push_expected();
        tx_ready = (mode == 0);
        start_dump();
        chk("dump_state", 32'(state_o), 32'd4);
        while (!done && k < 3000) begin
            if (mode == 1) tx_ready = (k < 10) ? 1'b0 : k[0];
            tick(1);
            k++;
            if (state_o == 3'd0) done = 1;
        end
        chk("dump_finished", 32'(done), 32'd1);
        chk("dump_drained", 32'(exp_q.size()), 32'd0);
        tx_ready = 1'b0;
        tick(2);
        chk("idle_valid_low", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int base, k;
        reset = 1'b1;
        tick(3);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        reset = 1'b0;
        tick(2);

        // Immediate trigger, two post-trigger records
        trig_mode = 2'd0;
        do_arm();
        chk("t1_armed", 32'(state_o), 32'd1);
        cap_on = 1;
        bus_cycle(32'h2020FFFF, 32'hAAAAAAAA, 1'b1, 2'b10, 1'b1, 1);
        chk("t1_post", 32'(state_o), 32'd2);
        bus_cycle(32'h00001000, 32'h12345678, 1'b0, 2'b00, 1'b1, 1);
        chk("t1_still_post", 32'(state_o), 32'd2);
        bus_cycle(32'h0000FFFC, 32'hDEADBEEF, 1'b1, 2'b01, 1'b1, 1);
        cap_on = 0;
        chk("t1_done", 32'(state_o), 32'd3);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_first_flags", 32'(m_flags[0]), 32'h09);
        run_dump(0);

        // Address-match trigger with wrap-around pre-trigger history
        trig_mode = 2'd1;
        trig_addr = 32'h12345678;
        trig_mask = 32'hFFFFFFFF;
        do_arm();
        cap_on = 1;
        for (int i = 0; i < 5; i++)
            bus_cycle((i == 2) ? 32'h12345679 : 32'h40000000 + 32'(i * 4),
                      32'h1000 + 32'(i), 1'b1, 2'b10, 1'b1, 1);
        chk("t2_no_match", 32'(state_o), 32'd1);
        chk("t2_count_sat", 32'(count), 32'd4);
        bus_cycle(32'h12345678, 32'hCAFEF00D, 1'b0, 2'b01, 1'b1, 1);
        chk("t2_match_post", 32'(state_o), 32'd2);
        bus_cycle(32'h50000000, 32'h2222, 1'b1, 2'b10, 1'b1, 1);
        chk("t2_post_hold", 32'(state_o), 32'd2);
        bus_cycle(32'h50000004, 32'h3333, 1'b1, 2'b10, 1'b1, 1);
        cap_on = 0;
        chk("t2_done", 32'(state_o), 32'd3);
        run_dump(0);

        // Fill-once mode, then berr mode without trigger and dump from ARMED
        trig_mode = 2'd3;
        do_arm();
        cap_on = 1;
        for (int i = 0; i < 6; i++) begin
            bus_cycle(32'h60000000 + 32'(i), 32'h600 + 32'(i), 1'b1, 2'b10, 1'b1, 1);
            if (i == 2) chk("t3_fill_armed", 32'(state_o), 32'd1);
            if (i == 3) begin
                chk("t3_fill_done", 32'(state_o), 32'd3);
                cap_on = 0;
            end
        end
        chk("t3_count", 32'(count), 32'd4);
        trig_mode = 2'd2;
        do_arm();
        chk("t3_rearm_done", 32'(state_o), 32'd1);
        cap_on = 1;
        for (int i = 0; i < 6; i++)
            bus_cycle(32'h70000000 + 32'(i), 32'h700 + 32'(i), 1'b0, 2'b10, 1'b1, 1);
        cap_on = 0;
        chk("t3_berr_armed", 32'(state_o), 32'd1);
        chk("t3_wrap_count", 32'(count), 32'd4);
        run_dump(0);

        // No-ack cycles, berr-only trigger, stalled sink
        trig_mode = 2'd2;
        do_arm();
        cap_on = 1;
        bus_cycle(32'h00000100, 32'h11111111, 1'b1, 2'b11, 1'b1, 0);
        bus_cycle(32'h00000104, 32'h22222222, 1'b0, 2'b11, 1'b1, 0);
        chk("t4_noack_armed", 32'(state_o), 32'd1);
        bus_cycle(32'h00000200, 32'h55AA55AA, 1'b0, 2'b11, 1'b0, 1);
        chk("t4_berr_post", 32'(state_o), 32'd2);
        bus_cycle(32'h00000300, 32'h33333333, 1'b1, 2'b01, 1'b1, 1);
        bus_cycle(32'h00000304, 32'h44444444, 1'b1, 2'b01, 1'b1, 1);
        cap_on = 0;
        chk("t4_done", 32'(state_o), 32'd3);
        run_dump(1);

        // Reset in the middle of a dump, then a clean re-arm
        trig_mode = 2'd0;
        do_arm();
        cap_on = 1;
        bus_cycle(32'h80000000, 32'h01020304, 1'b1, 2'b10, 1'b1, 1);
        bus_cycle(32'h80000004, 32'h05060708, 1'b1, 2'b10, 1'b1, 1);
        bus_cycle(32'h80000008, 32'h090A0B0C, 1'b1, 2'b10, 1'b1, 1);
        cap_on = 0;
        chk("t6_done", 32'(state_o), 32'd3);
        push_expected();
        tx_ready = 1'b1;
        base = acc_cnt;
        start_dump();
        k = 0;
        while (acc_cnt < base + 7 && k < 500) begin
            tick(1);
            k++;
        end
        chk("t6_reach_byte7", 32'(acc_cnt - base), 32'd7);
        tick(1);
        #2;
        chk("t6_pre_reset_valid", 32'(tx_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(tx_valid), 32'd0);
        chk("t6_rst_state", 32'(state_o), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        exp_q.delete();
        tx_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        do_arm();
        chk("t6_rearm", 32'(state_o), 32'd1);
        cap_on = 1;
        bus_cycle(32'h90000000, 32'hA0A0A0A0, 1'b0, 2'b00, 1'b1, 1);
        bus_cycle(32'h90000004, 32'hB0B0B0B0, 1'b1, 2'b01, 1'b1, 1);
        bus_cycle(32'h90000008, 32'hC0C0C0C0, 1'b0, 2'b10, 1'b1, 1);
        cap_on = 0;
        chk("t6_redone", 32'(state_o), 32'd3);
        chk("t6_recount", 32'(count), 32'd3);
        run_dump(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
